// File: rtl/burst_len_collector.sv
// burst_len_collector
//   Counts beats (s) between end-of-burst pulses (g) from the upstream burst
//   FSM and commits each burst length into a small FIFO. The FIFO head is
//   presented over a valid/ready handshake. Bursts that find the FIFO full
//   are discarded and counted in a saturating drop counter.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   s, g          beat strobe / end-of-burst pulse (registered upstream)
//   len_valid     FIFO not empty
//   len_ready     consumer accepts head entry
//   len_data      head entry burst length
//   len_sat       head entry length saturated at 2^CNT_W-1
//   busy          collector FSM not idle
//   drop_cnt      bursts lost to a full FIFO (saturating)
module burst_len_collector #(
    parameter int CNT_W  = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s,
    input  logic              g,
    output logic              len_valid,
    input  logic              len_ready,
    output logic [CNT_W-1:0]  len_data,
    output logic              len_sat,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   cmt_len_q, cmt_len_d;
    logic               cmt_sat_q, cmt_sat_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic [CNT_W:0]     mem_q [DEPTH];

    logic               pop, push, drop;
    logic [CNT_W-1:0]   cnt_inc;
    logic               sat_inc;

    // Counter holds at max instead of wrapping; sat flags the overflow.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign sat_inc = sat_q | (cnt_q == CNT_MAX);

    assign pop  = (level_q != '0) && len_ready;
    // A full FIFO still accepts the commit when the head leaves this cycle.
    assign push = (state_q == COMMIT) && ((level_q != FULL_LVL) || pop);
    assign drop = (state_q == COMMIT) && !push;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        cmt_len_d = cmt_len_q;
        cmt_sat_d = cmt_sat_q;
        case (state_q)
            // IDLE and COMMIT both start a fresh burst from a zero count.
            IDLE, COMMIT: begin
                cnt_d = '0;
                sat_d = 1'b0;
                if (g) begin
                    cmt_len_d = CNT_W'(s);
                    cmt_sat_d = 1'b0;
                    state_d   = COMMIT;
                end else if (s) begin
                    cnt_d   = CNT_W'(1);
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                if (g) begin
                    // A beat coincident with g still belongs to this burst.
                    cmt_len_d = s ? cnt_inc : cnt_q;
                    cmt_sat_d = s ? sat_inc : sat_q;
                    cnt_d     = '0;
                    sat_d     = 1'b0;
                    state_d   = COMMIT;
                end else if (s) begin
                    cnt_d = cnt_inc;
                    sat_d = sat_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
        drop_d   = (drop && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            cmt_len_q <= '0;
            cmt_sat_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            cmt_len_q <= cmt_len_d;
            cmt_sat_q <= cmt_sat_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            drop_q    <= drop_d;
        end
    end

    // Storage needs no reset: entries are only visible once level says so.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmt_sat_q, cmt_len_q};
    end

    assign len_valid           = (level_q != '0);
    assign {len_sat, len_data} = mem_q[rd_ptr_q];
    assign busy                = (state_q != IDLE);
    assign drop_cnt            = drop_q;

endmodule

// File: tb/tb_burst_len_collector.sv
module tb_burst_len_collector;

    logic       clk = 1'b0;
    logic       rst, s, g, len_ready;
    logic       len_valid, len_sat, busy;
    logic [7:0] len_data, drop_cnt;

    burst_len_collector #(.CNT_W(8), .DEPTH(4), .AW(2), .DROP_W(8)) dut (
        .clk(clk), .rst(rst), .s(s), .g(g),
        .len_valid(len_valid), .len_ready(len_ready),
        .len_data(len_data), .len_sat(len_sat),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [8:0] exp_q [$];   // {sat, len} in expected pop order

    typedef struct {
        int         n;
        logic [7:0] exp_len;
        logic       exp_sat;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    // n beats then one g pulse; returns just after the edge that samples g.
    task automatic burst(input int n, input logic [8:0] exp, input bit push);
        for (int i = 0; i < n; i++) begin
            s = 1'b1; tick();
        end
        s = 1'b0; g = 1'b1;
        if (push) exp_q.push_back(exp);
        tick();
        g = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin tick(); k++; end
        chk("drain_empty", exp_q.size(), 0);
        tick();
        chk("valid_after_drain", int'(len_valid), 0);
    endtask

    // Scoreboard: every accepted handshake pops one expected entry.
    always @(negedge clk) begin
        if (!rst && len_valid && len_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", int'(len_data), -1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("pop_data", int'({len_sat, len_data}), int'(e));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{5,   8'd5,   1'b0};
        vt[1] = '{1,   8'd1,   1'b0};
        vt[2] = '{0,   8'd0,   1'b0};
        vt[3] = '{7,   8'd7,   1'b0};
        vt[4] = '{255, 8'd255, 1'b0};
        vt[5] = '{256, 8'd255, 1'b1};
        vt[6] = '{300, 8'd255, 1'b1};
        vt[7] = '{2,   8'd2,   1'b0};

        rst = 1'b1; s = 1'b0; g = 1'b0; len_ready = 1'b1;
        idle(2);
        chk("rst_valid", int'(len_valid), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_drop",  int'(drop_cnt), 0);
        rst = 1'b0;
        idle(1);

        // Latency: valid two cycles after g, popped the next cycle.
        burst(5, 9'd5, 1'b1);
        chk("lat_busy_commit", int'(busy), 1);
        chk("lat_valid_early", int'(len_valid), 0);
        tick();
        chk("lat_valid", int'(len_valid), 1);
        chk("lat_data",  int'(len_data), 5);
        chk("lat_sat",   int'(len_sat), 0);
        tick();
        chk("lat_valid_fall", int'(len_valid), 0);
        idle(1);

        // g alone: one busy cycle, zero-length entry.
        burst(0, 9'd0, 1'b1);
        chk("g_only_busy", int'(busy), 1);
        tick();
        chk("g_only_busy_fall", int'(busy), 0);
        chk("g_only_data", int'(len_data), 0);
        drain();

        // Table-driven bursts including saturation and recovery.
        for (int i = 0; i < 8; i++) begin
            burst(vt[i].n, {vt[i].exp_sat, vt[i].exp_len}, 1'b1);
            idle(2);
        end
        drain();

        // Stall: 5 bursts into a 4-deep FIFO, the fifth is dropped.
        len_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            burst(i, 9'(i), i <= 4);
            idle(2);
        end
        chk("stall_drop", int'(drop_cnt), 1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", int'(len_valid), 1);
            chk("stall_data",  int'(len_data), 1);
            tick();
        end
        len_ready = 1'b1;
        drain();

        // Full FIFO with a pop in the COMMIT cycle: no drop, order kept.
        len_ready = 1'b0;
        for (int i = 6; i <= 9; i++) begin
            burst(i, 9'(i), 1'b1);
            idle(2);
        end
        burst(10, 9'd10, 1'b1);
        len_ready = 1'b1;
        tick();
        len_ready = 1'b0;
        chk("full_pop_drop",  int'(drop_cnt), 1);
        chk("full_pop_valid", int'(len_valid), 1);
        chk("full_pop_head",  int'(len_data), 7);
        idle(2);
        chk("full_pop_drop2", int'(drop_cnt), 1);
        len_ready = 1'b1;
        drain();

        // Reset mid-count with two entries queued.
        len_ready = 1'b0;
        burst(2, 9'd2, 1'b1); idle(2);
        burst(3, 9'd3, 1'b1); idle(2);
        s = 1'b1; idle(4);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(len_valid), 0);
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_drop",  int'(drop_cnt), 0);
        exp_q.delete();
        s = 1'b0;
        tick();
        rst = 1'b0;
        idle(1);
        len_ready = 1'b1;
        burst(3, 9'd3, 1'b1);
        idle(2);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
